sync_bus_capture_fifo: RTL and testbench
========================================

# sync_bus_capture_fifo

Destination-domain consumer of the bus synchronizer output. On each single-cycle enable pulse it captures the synchronized bus word into a small FIFO. It presents the words to the system controller through a valid/ready interface, so a controller that is momentarily busy never loses a word. Words arriving while the FIFO is full are dropped and reported through a sticky overflow flag.

## Interface
- BUS_WIDTH, 8, width of captured word (matches synchronizer BUS_WIDTH)
- DEPTH, 4, number of entries; power of two, >= 2
- AW (localparam), log2(DEPTH), pointer index width

- i_CLK  in  1  destination-domain clock, rising-edge
- i_RST  in  1  reset, asynchronous, active-low
- i_sync_bus  in  BUS_WIDTH  synchronized bus word, stable while i_enable_pulse is high
- i_enable_pulse  in  1  single-cycle strobe: capture i_sync_bus
- o_data  out  BUS_WIDTH  head-of-FIFO word; valid only while o_valid=1
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer accepts o_data this cycle
- o_overflow  out  1  sticky: a pulse arrived while full and was dropped
- i_clr_overflow  in  1  synchronous clear of o_overflow
- o_level  out  AW+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH x BUS_WIDTH register array. Pointers wr_ptr/rd_ptr are AW+1 bits and wrap modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr). full = MSBs differ and the low AW bits are equal.
- write = i_enable_pulse && (!full || pop). A write stores i_sync_bus at mem[wr_ptr[AW-1:0]], then wr_ptr+1.
- pop = o_valid && i_ready. A pop increments rd_ptr.
- Full with simultaneous pop: the write is accepted and the level stays DEPTH. No overflow is flagged.
- Full without pop: the word is discarded, pointers do not change, and o_overflow is set.
- Empty with i_ready=1: no effect; rd_ptr does not move.
- o_overflow: set on a dropped write. Otherwise cleared by i_clr_overflow. If set and clear occur in the same cycle, set wins.
- o_data = mem[rd_ptr[AW-1:0]] (first-word fall-through). o_valid = !empty.
- o_level = wr_ptr - rd_ptr, computed in AW+1 bits, so it stays correct across the wrap.
- Reset (i_RST=0, asynchronous): pointers 0, all mem entries 0, o_overflow 0. Hence o_valid=0, o_level=0, o_data=0. Reset mid-operation discards all stored words immediately.
- i_enable_pulse held high for multiple cycles is treated as one write per cycle. The upstream synchronizer guarantees single-cycle pulses.

## Timing
- Capture latency: a pulse sampled at edge N makes o_valid=1 and o_data=word after edge N (same cycle as the FIFO's next state). One-cycle latency from pulse to valid.
- Pop: o_valid && i_ready sampled at edge M. The next word, or o_valid=0, appears after edge M.
- Back-to-back pulses with i_ready held high: one word in, one word out per cycle, and o_level stays at 1.
- o_overflow asserts the cycle after the dropping edge. It deasserts the cycle after the clear edge.
- Reset deassertion: operation starts at the first rising edge with i_RST=1.

## Test plan
All scenarios use BUS_WIDTH=4, DEPTH=4.
- Reset: drive i_RST=0 mid-stream with 3 words stored -> o_valid=0, o_level=0, o_overflow=0, o_data=0 immediately, without waiting for a clock edge.
- Single capture: i_sync_bus=4'b1011 with one pulse and i_ready=0 -> next cycle o_valid=1, o_data=4'b1011, o_level=1. Then i_ready=1 for 1 cycle -> o_valid=0, o_level=0.
- Fill and order: pulses carrying 4'h1, 4'h2, 4'h3, 4'h4 with i_ready=0 -> o_level=4. Then draining with i_ready=1 yields 1, 2, 3, 4 on consecutive cycles, and o_overflow stays 0.
- Overflow: with the FIFO full, send a pulse carrying 4'hF with i_ready=0 -> o_overflow=1, o_level=4, and 4'hF never appears on o_data. Asserting i_clr_overflow for 1 cycle -> o_overflow=0.
- Full with simultaneous pop: FIFO full (1, 2, 3, 4), pulse carrying 4'h5 in the same cycle as i_ready=1 -> o_overflow=0, o_level=4. The drain sequence is then 2, 3, 4, 5.
- Wrap-around: 10 push/pop pairs alternating with varying data -> every word returns in order, and o_level never exceeds 1 after pointers wrap past 2*DEPTH.

Source files
------------

// File: rtl/sync_bus_capture_fifo_if.sv
// Handshake bundle between the capture FIFO and its surroundings.
// The slave side is the FIFO. The master side is the synchronizer and controller that drive it.
interface sync_bus_capture_fifo_if #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned DEPTH     = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [BUS_WIDTH-1:0] i_sync_bus;
    logic                 i_enable_pulse;
    logic [BUS_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_overflow;
    logic                 i_clr_overflow;
    logic [AW:0]          o_level;

    modport slave (
        input  i_sync_bus, i_enable_pulse, i_ready, i_clr_overflow,
        output o_data, o_valid, o_overflow, o_level
    );

    modport master (
        output i_sync_bus, i_enable_pulse, i_ready, i_clr_overflow,
        input  o_data, o_valid, o_overflow, o_level
    );
endinterface

// File: rtl/sync_bus_capture_fifo.sv
// Captures synchronized bus words into a small first-word-fall-through FIFO with valid/ready output.
// Words that arrive while the FIFO is full are dropped and raise a sticky overflow flag.
module sync_bus_capture_fifo #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    sync_bus_capture_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 overflow;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 write;
    logic                 drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && bus.i_ready;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    assign write = bus.i_enable_pulse && (!full || pop);
    assign drop  = bus.i_enable_pulse && full && !pop;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (write) begin
                mem[wr_ptr[AW-1:0]] <= bus.i_sync_bus;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.i_clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.o_data     = mem[rd_ptr[AW-1:0]];
    assign bus.o_valid    = !empty;
    assign bus.o_overflow = overflow;
    assign bus.o_level    = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_sync_bus_capture_fifo.sv
// Scoreboard bench for sync_bus_capture_fifo: expected words are queued when they are pushed and compared when they are popped.
module tb_sync_bus_capture_fifo;
    localparam int unsigned BW    = 4;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst_n;

    int unsigned n_cmp;
    int unsigned n_err;

    logic [BW-1:0] exp_q[$];
    logic          exp_ovf;

    sync_bus_capture_fifo_if #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) bus ();

    sync_bus_capture_fifo #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .i_CLK (clk),
        .i_RST (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs and updates the model. After the edge it compares the DUT state.
    task automatic step(input logic en, input logic [BW-1:0] data, input logic rdy, input logic clr);
        logic pop_m;
        logic full_m;
        bus.i_enable_pulse = en;
        bus.i_sync_bus     = data;
        bus.i_ready        = rdy;
        bus.i_clr_overflow = clr;
        full_m = (exp_q.size() == DEPTH);
        pop_m  = (exp_q.size() != 0) && rdy;
        if (pop_m) begin
            check("pop_data", bus.o_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (en) begin
            if (!full_m || pop_m) exp_q.push_back(data);
            else                  exp_ovf = 1'b1;
        end
        if (!(en && full_m && !pop_m) && clr) exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        bus.i_enable_pulse = 1'b0;
        bus.i_ready        = 1'b0;
        bus.i_clr_overflow = 1'b0;
        check("valid", bus.o_valid, exp_q.size() != 0);
        check("level", bus.o_level, exp_q.size());
        check("overflow", bus.o_overflow, exp_ovf);
        if (exp_q.size() != 0) check("head", bus.o_data, exp_q[0]);
    endtask

    task automatic drain();
        int unsigned guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2*DEPTH) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_ovf = 1'b0;
        bus.i_enable_pulse = 1'b0;
        bus.i_sync_bus     = '0;
        bus.i_ready        = 1'b0;
        bus.i_clr_overflow = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_valid", bus.o_valid, 0);
        check("rst_level", bus.o_level, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_ovf", bus.o_overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single capture followed by a single pop.
        step(1'b1, 4'b1011, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill to DEPTH, then drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, BW'(i), 1'b0, 1'b0);
        drain();

        // Overflow while full, set beating clear, then a clear.
        for (int i = 1; i <= 4; i++) step(1'b1, BW'(i), 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b0, 1'b0);
        step(1'b1, 4'hE, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        drain();

        // Full with simultaneous pop: the write is accepted and no overflow is flagged.
        for (int i = 1; i <= 4; i++) step(1'b1, BW'(i), 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        drain();

        // Wrap-around with alternating pushes and pops.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, BW'($urandom_range(0, 15)), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Back-to-back pulses with ready held high.
        for (int i = 0; i < 8; i++) step(1'b1, BW'(i + 7), 1'b1, 1'b0);
        drain();

        // Asynchronous reset with three words stored.
        for (int i = 0; i < 3; i++) step(1'b1, BW'(i + 9), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_level", bus.o_level, 0);
        check("midrst_data", bus.o_data, 0);
        check("midrst_ovf", bus.o_overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'h6, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
